btn_sw_dev_in: RTL and testbench
================================

// Module: btn_sw_dev_in
// PURPOSE
//  Input-side GPIO peripheral, the read-direction counterpart of the LED/counter_set output port.
//  - Synchronises and debounces 8 slide switches and 4 push buttons.
//  - Latches button press/release events into sticky flags.
//  - Presents one 32-bit status word that the CPU polls.
//  - A CPU read strobe clears the event flags (read-to-clear), giving reliable polling without lost edges.
// PARAMETERS
//  DB_CYCLES  16'd50000  consecutive stable clk cycles required before a debounced value changes (>=1)
//  DB_W       16         width of each debounce counter; DB_CYCLES must fit in DB_W bits
// PORTS
//  clk              in   1   system clock; all flops update on the rising edge
//  rst              in   1   reset, synchronous, active-high
//  sw_in            in   8   raw asynchronous switch levels
//  btn_in           in   4   raw asynchronous button levels, 1 = pressed
//  GPIOe0000000_re  in   1   CPU read strobe for the status word, one cycle per read
//  Peripheral_out   out  32  status word, combinational from internal registers
//  irq_pending      out  1   registered; 1 while any press or release flag is set
// BEHAVIOUR
//  Reset
//   - On a clk edge with rst=1: sync flops, debounced levels, counters, all flags and irq_pending go to 0.
//   - Peripheral_out then reads 32'h0.
//  Synchronisation
//   - Each input passes through 2 flops.
//   - s = second-stage output.
//  Debounce (per bit, with stable level d)
//   - If s==d, the counter clears to 0.
//   - Otherwise the counter increments.
//   - On the edge where the counter would reach DB_CYCLES, d<=s and the counter clears.
//   - Latency: raw change -> d change = 2 + DB_CYCLES edges, provided the input stays stable.
//   - A glitch shorter than DB_CYCLES cycles never changes d.
//  Events (buttons only)
//   - press_evt[i] is a 1-cycle pulse when d goes 0->1.
//   - release_evt[i] is a 1-cycle pulse when d goes 1->0.
//  Sticky flags press_f[3:0], rel_f[3:0], ovr_f[3:0]
//   - Set: press_f[i] <= 1 on press_evt[i]; rel_f[i] likewise on release_evt[i].
//   - Overrun: ovr_f[i] <= 1 on press_evt[i] while press_f[i] is already 1 and not being cleared this edge.
//   - Clear: on an edge with GPIOe0000000_re=1, all press_f, rel_f and ovr_f clear.
//   - The CPU samples the pre-clear value during the strobe cycle.
//   - Simultaneous set and read-clear: the set wins; the flag is 1 after the edge and no overrun is recorded.
//  Status word Peripheral_out
//   - [31:24] = 0
//   - [23:16] = debounced sw
//   - [15:12] = debounced btn
//   - [11:8]  = press_f
//   - [7:4]   = rel_f
//   - [3:0]   = ovr_f
//  irq_pending
//   - Next-state |{press_f,rel_f}, registered, so it tracks the flags with 0 extra latency.
//   - Deasserts on the edge after a read-clear unless a new event arrives on that edge.
//  Edge cases
//   - A switch/button held at 1 through reset debounces to 1 after 2+DB_CYCLES edges.
//   - For buttons, this raises a press event on that edge. This is required behaviour.
//   - rst mid-debounce discards the partial count.
//   - A read strobe with no flags set is harmless.
//   - Back-to-back strobes are allowed.
// STRUCTURE
//  - Shared package/header (io_defs) holds:
//    - status field constants SW_LSB=16, BTN_LSB=12, PRESS_LSB=8, REL_LSB=4, OVR_LSB=0
//    - the peripheral base addresses
//  - Sub-module debounce_cell (params DB_CYCLES, DB_W):
//    - 1-bit sync + counter + stable level + rise/fall pulses
//    - 12 instances, generate loop
//  - Top level holds the flags, the status mux and irq_pending.
// TESTING (sim with DB_CYCLES=4, DB_W=3)
//  1. Reset: rst=1 for 2 edges, all inputs 0 -> Peripheral_out=32'h0, irq_pending=0.
//  2. Switch: sw_in=8'hA5 held -> [23:16]=8'hA5 exactly 6 edges later; no flag bits set.
//  3. Glitch: btn_in[0] high 3 cycles then low -> d never changes, press_f=0, irq_pending=0.
//  4. Press/release: btn_in[2] high 10 cycles then low 10 cycles -> press_f=4'b0100, rel_f=4'b0100,
//     irq_pending=1; strobe once -> flags 0, irq_pending=0 next edge.
//  5. Overrun: press btn1 twice with no read -> press_f[1]=1, ovr_f[1]=1; one strobe clears both.
//  6. Collision: press_evt[3] on the same edge as the strobe -> pre-edge read shows press_f[3]=0;
//     after the edge press_f[3]=1, ovr_f[3]=0, irq_pending=1.

Source files
------------

// File: rtl/btn_sw_dev_in_pkg.sv
// Shared constants for the GPIO input port: status-word field positions
// and the peripheral base addresses of the I/O slice.
package btn_sw_dev_in_pkg;

  localparam int SW_LSB    = 16;
  localparam int BTN_LSB   = 12;
  localparam int PRESS_LSB = 8;
  localparam int REL_LSB   = 4;
  localparam int OVR_LSB   = 0;

  localparam int N_SW  = 8;
  localparam int N_BTN = 4;

  localparam logic [31:0] GPIO_IN_BASE = 32'hE000_0000;
  localparam logic [31:0] LED_OUT_BASE = 32'hF000_0000;

endpackage

// File: rtl/btn_sw_dev_in_debounce_cell.sv
// One-bit two-flop synchroniser plus stability counter. The level only moves
// after DB_CYCLES consecutive cycles of disagreement; rise/fall mark that edge.
module debounce_cell #(
  parameter logic [15:0] DB_CYCLES = 16'd50000,
  parameter int          DB_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [DB_W-1:0] LAST = DB_W'(DB_CYCLES - 16'd1);

  logic            meta;
  logic            s;
  logic [DB_W-1:0] cnt;
  logic            done;

  // done is high in the cycle whose closing edge commits the new level
  assign done = (s != level) && (cnt == LAST);
  assign rise = done & s;
  assign fall = done & ~s;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b0;
      s     <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      meta <= raw;
      s    <= meta;
      if (s == level) begin
        cnt <= '0;
      end else if (done) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/btn_sw_dev_in.sv
// GPIO input port: debounced switches and buttons, sticky press/release/overrun
// flags cleared by the CPU read strobe, and a polled 32-bit status word.
module btn_sw_dev_in
  import btn_sw_dev_in_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES = 16'd50000,
  parameter int          DB_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sw_in,
  input  logic [3:0]  btn_in,
  input  logic        GPIOe0000000_re,
  output logic [31:0] Peripheral_out,
  output logic        irq_pending
);

  localparam int N_IN = N_SW + N_BTN;

  logic [N_IN-1:0] raw_all;
  logic [N_IN-1:0] lvl_all;
  logic [N_IN-1:0] rise_all;
  logic [N_IN-1:0] fall_all;

  assign raw_all = {btn_in, sw_in};

  for (genvar i = 0; i < N_IN; i++) begin : g_db
    debounce_cell #(
      .DB_CYCLES (DB_CYCLES),
      .DB_W      (DB_W)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_all[i]),
      .level (lvl_all[i]),
      .rise  (rise_all[i]),
      .fall  (fall_all[i])
    );
  end

  // Switch edges carry no events; fold them into a deliberately unused sink.
  logic unused_sw_edges;
  assign unused_sw_edges = ^{rise_all[N_SW-1:0], fall_all[N_SW-1:0]};

  logic [N_SW-1:0]  sw_d;
  logic [N_BTN-1:0] btn_d;
  logic [N_BTN-1:0] press_evt;
  logic [N_BTN-1:0] release_evt;

  assign sw_d        = lvl_all[N_SW-1:0];
  assign btn_d       = lvl_all[N_IN-1:N_SW];
  assign press_evt   = rise_all[N_IN-1:N_SW];
  assign release_evt = fall_all[N_IN-1:N_SW];

  logic [N_BTN-1:0] press_f, rel_f, ovr_f;
  logic [N_BTN-1:0] press_n, rel_n, ovr_n;
  logic [N_BTN-1:0] keep;

  // Read protocol: GPIOe0000000_re is a single-cycle strobe with no
  // back-pressure. The CPU samples Peripheral_out in the strobe cycle, and
  // the flags clear on the closing edge; events on that same edge survive.
  always_comb begin
    keep    = GPIOe0000000_re ? '0 : {N_BTN{1'b1}};
    press_n = (press_f & keep) | press_evt;
    rel_n   = (rel_f & keep) | release_evt;
    ovr_n   = (ovr_f & keep) | (press_evt & press_f & keep);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      press_f     <= '0;
      rel_f       <= '0;
      ovr_f       <= '0;
      irq_pending <= 1'b0;
    end else begin
      press_f     <= press_n;
      rel_f       <= rel_n;
      ovr_f       <= ovr_n;
      irq_pending <= |{press_n, rel_n};
    end
  end

  always_comb begin
    Peripheral_out                    = '0;
    Peripheral_out[SW_LSB +: N_SW]    = sw_d;
    Peripheral_out[BTN_LSB +: N_BTN]  = btn_d;
    Peripheral_out[PRESS_LSB +: N_BTN] = press_f;
    Peripheral_out[REL_LSB +: N_BTN]  = rel_f;
    Peripheral_out[OVR_LSB +: N_BTN]  = ovr_f;
  end

endmodule

// File: tb/tb_btn_sw_dev_in.sv
// Directed bench for btn_sw_dev_in with a short debounce window (4 cycles).
module tb_btn_sw_dev_in;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sw_in;
  logic [3:0]  btn_in;
  logic        re;
  logic [31:0] pout;
  logic        irq;

  int errors = 0;
  int checks = 0;

  btn_sw_dev_in #(
    .DB_CYCLES (16'd4),
    .DB_W      (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sw_in           (sw_in),
    .btn_in          (btn_in),
    .GPIOe0000000_re (re),
    .Peripheral_out  (pout),
    .irq_pending     (irq)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst    = 1'b1;
    sw_in  = 8'h00;
    btn_in = 4'h0;
    re     = 1'b0;

    // 1. reset
    edges(2);
    rst = 1'b0;
    chk("reset_out", pout, 32'h0000_0000);
    chk("reset_irq", {31'b0, irq}, 32'h0);

    // 2. switches appear exactly 6 edges after the raw change
    sw_in = 8'hA5;
    edges(5);
    chk("sw_before_6", pout, 32'h0000_0000);
    edges(1);
    chk("sw_at_6", pout, 32'h00A5_0000);
    chk("sw_irq", {31'b0, irq}, 32'h0);

    // 3. a 3-cycle glitch on btn0 is filtered
    btn_in = 4'b0001;
    edges(3);
    btn_in = 4'b0000;
    edges(10);
    chk("glitch_out", pout, 32'h00A5_0000);
    chk("glitch_irq", {31'b0, irq}, 32'h0);

    // 4. press and release btn2, then read-clear
    btn_in = 4'b0100;
    edges(10);
    chk("press2_out", pout, 32'h00A5_4400);
    chk("press2_irq", {31'b0, irq}, 32'h1);
    btn_in = 4'b0000;
    edges(10);
    chk("rel2_out", pout, 32'h00A5_0440);
    re = 1'b1;
    chk("rd2_preclear", pout, 32'h00A5_0440);
    edges(1);
    re = 1'b0;
    chk("rd2_cleared", pout, 32'h00A5_0000);
    chk("rd2_irq", {31'b0, irq}, 32'h0);

    // 5. two presses of btn1 without a read record an overrun
    btn_in = 4'b0010;
    edges(10);
    btn_in = 4'b0000;
    edges(10);
    btn_in = 4'b0010;
    edges(10);
    btn_in = 4'b0000;
    edges(10);
    chk("ovr1_out", pout, 32'h00A5_0222);
    chk("ovr1_irq", {31'b0, irq}, 32'h1);
    re = 1'b1;
    edges(1);
    re = 1'b0;
    chk("ovr1_cleared", pout, 32'h00A5_0000);
    chk("ovr1_irq_clr", {31'b0, irq}, 32'h0);

    // 6. press event of btn3 coincides with the read strobe
    btn_in = 4'b1000;
    edges(5);
    re = 1'b1;
    chk("coll_preedge", pout, 32'h00A5_0000);
    edges(1);
    re = 1'b0;
    chk("coll_after", pout, 32'h00A5_8800);
    chk("coll_irq", {31'b0, irq}, 32'h1);

    // release btn3, then back-to-back strobes (second one finds no flags)
    btn_in = 4'b0000;
    edges(10);
    chk("rel3_out", pout, 32'h00A5_0880);
    re = 1'b1;
    edges(2);
    re = 1'b0;
    chk("b2b_out", pout, 32'h00A5_0000);
    chk("b2b_irq", {31'b0, irq}, 32'h0);

    // 7. button held through reset debounces afterwards and raises a press
    sw_in  = 8'h00;
    btn_in = 4'b0001;
    rst    = 1'b1;
    edges(1);
    rst = 1'b0;
    chk("hold_rst_out", pout, 32'h0000_0000);
    chk("hold_rst_irq", {31'b0, irq}, 32'h0);
    edges(5);
    chk("hold_before_6", pout, 32'h0000_0000);
    edges(1);
    chk("hold_at_6", pout, 32'h0000_1100);
    chk("hold_irq", {31'b0, irq}, 32'h1);

    // 8. reset mid-debounce discards the partial count
    btn_in = 4'b0000;
    sw_in  = 8'h3C;
    edges(4);
    rst = 1'b1;
    edges(1);
    rst = 1'b0;
    chk("mid_rst_out", pout, 32'h0000_0000);
    edges(5);
    chk("mid_rst_before_6", pout, 32'h0000_0000);
    edges(1);
    chk("mid_rst_at_6", pout, 32'h003C_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
